// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserialiser with idle-byte alignment.
// It hunts for IDLE_BYTE at any bit offset, confirms BC_LOCK aligned idles, then emits each non-idle byte.
module serial_to_parallel #(
  parameter logic [7:0] IDLE_BYTE = 8'hBC,
  parameter int         BC_LOCK   = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int              BCW       = $clog2(BC_LOCK + 1);
  localparam logic [BCW-1:0]  BC_LOCK_V = BC_LOCK[BCW-1:0];
  localparam logic [BCW-1:0]  BC_ONE    = BCW'(1);

  typedef enum logic [1:0] {HUNT, COUNT, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] bc_cnt_q, bc_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           active_q, active_d;

  logic [7:0]     cand;
  logic           boundary;
  logic [BCW-1:0] bc_inc;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    cand      = {shift_q[6:0], data_in};
    boundary  = (bit_cnt_q == 3'd7);
    // Idle count saturates at the lock threshold rather than wrapping.
    bc_inc    = (bc_cnt_q == BC_LOCK_V) ? bc_cnt_q : bc_cnt_q + BC_ONE;
    state_d   = state_q;
    shift_d   = cand;
    bit_cnt_d = 3'd0;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;
    unique case (state_q)
      HUNT: begin
        bc_cnt_d = '0;
        if (cand == IDLE_BYTE) begin
          bc_cnt_d = BC_ONE;
          if (BC_ONE == BC_LOCK_V) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (cand == IDLE_BYTE) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == BC_LOCK_V) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            state_d  = HUNT;
            bc_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary && (cand != IDLE_BYTE)) begin
          data_d  = cand;
          valid_d = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomised scoreboard bench for serial_to_parallel against a bit-history reference model.
module tb_serial_to_parallel;

  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         BCL  = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       din   = 1'b0;
  logic [7:0] dout;
  logic       vout;
  logic       act;

  serial_to_parallel #(.IDLE_BYTE(IDLE), .BC_LOCK(BCL)) dut (
    .clk_8f   (clk),
    .reset    (rst_n),
    .data_in  (din),
    .data_out (dout),
    .valid_out(vout),
    .active   (act)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       a;
    logic [7:0] d;
  } status_t;

  status_t    st_q[$];
  logic [7:0] byte_q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model: full bit history since reset, alignment anchor as a bit index.
  logic       hist[$];
  int         anchor;
  int         runs;
  logic       m_locked;
  logic [7:0] m_data;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    anchor   = -1;
    runs     = 0;
    m_locked = 1'b0;
    m_data   = 8'h00;
    byte_q.delete();
    st_q.delete();
  endfunction

  function automatic void model_step(logic b);
    logic [7:0] w;
    logic       v;
    int         n;
    v = 1'b0;
    hist.push_back(b);
    n = hist.size();
    for (int i = 0; i < 8; i++) w[i] = (n - 1 - i >= 0) ? hist[n-1-i] : 1'b0;
    if (m_locked) begin
      if (((n - anchor) % 8 == 0) && (w != IDLE)) begin
        v      = 1'b1;
        m_data = w;
        byte_q.push_back(w);
      end
    end else if (anchor < 0) begin
      if (w == IDLE) begin
        anchor = n;
        runs   = 1;
        if (runs == BCL) m_locked = 1'b1;
      end
    end else if ((n - anchor) % 8 == 0) begin
      if (w == IDLE) begin
        runs++;
        if (runs == BCL) m_locked = 1'b1;
      end else begin
        anchor = -1;
        runs   = 0;
      end
    end
    st_q.push_back({v, m_locked, m_data});
  endfunction

  // Monitor: one expected status per driven bit, byte queue popped on each strobe.
  initial begin
    forever begin
      status_t e;
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        check("valid_out", {31'd0, vout}, {31'd0, e.v});
        check("active", {31'd0, act}, {31'd0, e.a});
        check("data_out", {24'd0, dout}, {24'd0, e.d});
        if (vout === 1'b1) begin
          if (byte_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
          else                    check("strobe_byte", {24'd0, dout}, {24'd0, byte_q.pop_front()});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    model_step(b);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_data_out", {24'd0, dout}, 32'd0);
    check("rst_valid_out", {31'd0, vout}, 32'd0);
    check("rst_active", {31'd0, act}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_data_out", {24'd0, dout}, 32'd0);
    check("init_valid_out", {31'd0, vout}, 32'd0);
    check("init_active", {31'd0, act}, 32'd0);
    #1;
    rst_n = 1'b1;

    // Lock on four idles; active rises exactly on bit 32.
    for (int k = 0; k < 3; k++) send_byte(IDLE);
    for (int i = 7; i >= 1; i--) send_bit(IDLE[i]);
    check("active_before_bit32", {31'd0, act}, 32'd0);
    send_bit(IDLE[0]);
    check("active_on_bit32", {31'd0, act}, 32'd1);

    // Single data byte, then an idle.
    send_byte(8'hA5);
    check("a5_valid", {31'd0, vout}, 32'd1);
    check("a5_data", {24'd0, dout}, 32'hA5);
    send_bit(IDLE[7]);
    check("a5_valid_one_cycle", {31'd0, vout}, 32'd0);
    for (int i = 6; i >= 0; i--) send_bit(IDLE[i]);
    check("idle_no_valid", {31'd0, vout}, 32'd0);
    check("idle_hold_data", {24'd0, dout}, 32'hA5);

    // Back-to-back data bytes.
    send_byte(8'h01);
    check("b2b_01", {24'd0, dout}, 32'h01);
    send_byte(8'h02);
    check("b2b_02", {24'd0, dout}, 32'h02);
    send_byte(8'h03);
    check("b2b_03", {24'd0, dout}, 32'h03);
    check("b2b_still_active", {31'd0, act}, 32'd1);

    // Reset mid-byte while locked; no output until re-lock.
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    do_reset();
    send_byte(8'h55);
    check("after_rst_inactive", {31'd0, act}, 32'd0);
    check("after_rst_data", {24'd0, dout}, 32'd0);
    for (int k = 0; k < 4; k++) send_byte(IDLE);
    check("relock", {31'd0, act}, 32'd1);

    // Random bit offset before the idle run.
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    for (int k = 0; k < 4; k++) send_byte(IDLE);
    send_byte(8'h3C);
    check("offset_data_3c", {24'd0, dout}, 32'h3C);
    check("offset_valid", {31'd0, vout}, 32'd1);

    // Broken idle run returns to hunt, then locks on a fresh run.
    do_reset();
    send_byte(IDLE);
    send_byte(IDLE);
    send_byte(8'h00);
    check("broken_run_inactive", {31'd0, act}, 32'd0);
    for (int k = 0; k < 3; k++) send_byte(IDLE);
    check("second_run_not_yet", {31'd0, act}, 32'd0);
    send_byte(IDLE);
    check("second_run_locked", {31'd0, act}, 32'd1);

    // Random traffic: noise while hunting, lock, then mixed idle/data bytes.
    do_reset();
    for (int i = 0; i < 40; i++) send_bit(1'($urandom));
    for (int k = 0; k < 4; k++) send_byte(IDLE);
    for (int k = 0; k < 120; k++) begin
      r = ($urandom_range(0, 3) == 0) ? IDLE : 8'($urandom);
      send_byte(r);
    end

    @(posedge clk);
    #2;
    check("byte_queue_drained", byte_q.size(), 32'd0);
    check("status_queue_drained", st_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter IDLE_BYTE, default 8'hBC; idle/alignment byte carried on the serial line when no valid data is present.
REQ-002 Parameter BC_LOCK, default 4; number of consecutive aligned IDLE_BYTE bytes required to declare lock.
REQ-003 clk_8f  input  1  bit clock; one serial bit per rising edge; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset==0 forces the reset state immediately.
REQ-005 data_in  input  1  serial bit stream, MSB of each byte first.
REQ-006 data_out  output  8  last received non-idle byte, registered.
REQ-007 valid_out  output  1  one-cycle strobe; data_out holds a new byte.
REQ-008 active  output  1  high while byte alignment is locked.

Function
REQ-009 Shift register shift[7:0] SHALL take shift <= {shift[6:0], data_in} every clk_8f edge in every state.
REQ-010 Candidate byte cand = {shift[6:0], data_in}, i.e. the 8 most recent bits including the one sampled this edge.
REQ-011 State machine SHALL have three states: HUNT, COUNT and LOCKED; the reset state is HUNT.
REQ-012 In HUNT, bit_cnt and bc_cnt are held at 0 and cand is checked on every edge (any bit offset); cand==IDLE_BYTE -> COUNT, bit_cnt<=0, bc_cnt<=1.
REQ-013 bit_cnt is 3 bits, increments every edge in COUNT and LOCKED, and wraps 7->0; a byte boundary is an edge where bit_cnt==7.
REQ-014 In COUNT at a boundary, cand==IDLE_BYTE -> bc_cnt+1; if the new count equals BC_LOCK -> LOCKED, and active is 1 from that edge.
REQ-015 In COUNT at a boundary, cand!=IDLE_BYTE -> HUNT with bc_cnt<=0 and no output strobe.
REQ-016 Edges in COUNT that are not boundaries SHALL NOT change state or bc_cnt.
REQ-017 In LOCKED at a boundary with cand!=IDLE_BYTE: data_out<=cand and valid_out<=1 on the same edge (0 cycles of latency after the byte's last bit is sampled).
REQ-018 In LOCKED at a boundary with cand==IDLE_BYTE: valid_out<=0 and data_out holds its value.
REQ-019 valid_out SHALL be 0 on every edge that is not a LOCKED boundary; it is never high for two consecutive cycles.
REQ-020 Lock loss: consecutive non-idle bytes are not a lock-loss condition; LOCKED is exited only by reset.
REQ-021 data_out SHALL change only on a valid_out assertion or on reset.
REQ-022 bc_cnt SHALL be wide enough to hold BC_LOCK (3 bits at the default); it saturates and never wraps.

Reset
REQ-023 reset==0 SHALL asynchronously set data_out=8'h00, valid_out=0, active=0, shift=8'h00, bit_cnt=0, bc_cnt=0, state=HUNT.
REQ-024 Reset asserted mid-byte or in LOCKED SHALL discard the partial byte; re-lock requires a fresh BC_LOCK idle sequence after release.
REQ-025 The first rising edge after reset deassertion SHALL sample data_in normally.

Verification
REQ-026 Four 8'hBC bytes MSB-first from reset release -> active rises on the edge sampling the 32nd bit, and valid_out stays 0 throughout.
REQ-027 Locked, then byte 8'hA5 -> valid_out=1 for exactly one cycle with data_out=8'hA5 on its 8th bit; a following 8'hBC -> valid_out=0 and data_out stays 8'hA5.
REQ-028 3 random bits, then 4x8'hBC, then 8'h3C -> lock at the correct offset and data_out=8'h3C.
REQ-029 2x8'hBC, then 8'h00, then 4x8'hBC -> return to HUNT after the 8'h00 with active=0, then lock after the second idle run.
REQ-030 Reset pulsed low mid-byte while locked -> all outputs are 0 at once; afterwards 8'h55 yields no valid_out until 4x8'hBC has been seen again.
REQ-031 Back-to-back 8'h01, 8'h02, 8'h03 while locked -> three single-cycle valid_out strobes 8 cycles apart, with data_out 01, 02, 03.
